// File: rtl/tsr_pkg.sv
// Shared widths, entry layout, FSM states and beat packing for ts_report_packer.
// Beat layouts are fixed at 32 bits regardless of how the FIFO is sized.
package tsr_pkg;

  localparam int UTC_W   = 6;
  localparam int CNT_W   = 26;
  localparam int DRIFT_W = 13;
  localparam int SEQ_W   = 8;

  localparam logic [3:0] TSR_TAG = 4'hA;

  typedef struct packed {
    logic [UTC_W-1:0]   utc;
    logic [CNT_W-1:0]   clk_counter;
    logic [DRIFT_W-1:0] drift;
    logic [SEQ_W-1:0]   seq;
    logic               lost;
  } tsr_entry_t;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} tsr_state_e;

  function automatic logic [31:0] pack_beat0(input tsr_entry_t e);
    return {TSR_TAG, e.seq, e.lost, e.utc, e.drift};
  endfunction

  function automatic logic [31:0] pack_beat1(input tsr_entry_t e);
    return {6'b0, e.clk_counter};
  endfunction

endpackage

// File: rtl/tsr_sync_fifo.sv
// Synchronous FIFO with the head and the entry behind it readable combinationally.
// Write lands at the clock edge; a same-cycle push and pop while full is legal.
module tsr_sync_fifo #(
  parameter int WIDTH = 54,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_dat,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [WIDTH-1:0]           o_next,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // o_next lets the reader start the following packet on the same edge it pops
  assign o_head  = r_mem[r_rd_ptr];
  assign o_next  = r_mem[r_rd_ptr + AW'(1)];
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/ts_report_packer.sv
// Queues PPS timestamp tuples and streams them as 2-beat 32-bit valid/ready packets; ts_valid->m_valid 2 cycles.
// Beats hold under m_ready low; tuples arriving while full are dropped (counter only with TSR_DROP_COUNT_EN).
module ts_report_packer
  import tsr_pkg::*;
#(
  parameter int UTC_SECONDS_WIDTH       = UTC_W,
  parameter int COUNT_LAST_SECOND_WIDTH = CNT_W,
  parameter int DRIFT_COUNT_WIDTH       = DRIFT_W,
  parameter int FIFO_DEPTH              = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ts_valid,
  input  logic [UTC_SECONDS_WIDTH-1:0]       ts_utc_seconds,
  input  logic [COUNT_LAST_SECOND_WIDTH-1:0] ts_clk_counter,
  input  logic [DRIFT_COUNT_WIDTH-1:0]       ts_drift,
  output logic                               m_valid,
  output logic [31:0]                        m_data,
  output logic                               m_last,
  input  logic                               m_ready,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic [15:0]                        drop_count
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  tsr_state_e       r_state, w_next_state;
  tsr_entry_t       w_wr_entry, w_head, w_next;
  logic             w_full, w_empty, w_push, w_pop, w_drop, w_load;
  logic [LVL_W-1:0] w_level;
  logic [SEQ_W-1:0] r_seq;
  logic             r_lost_pend;
  logic [31:0]      r_data, w_data_nxt;

  assign w_pop      = (r_state == BEAT1) && m_ready;
  assign w_push     = ts_valid && (!w_full || w_pop);
  assign w_drop     = ts_valid && !w_push;
  assign w_wr_entry = {ts_utc_seconds, ts_clk_counter, ts_drift, r_seq, r_lost_pend};

  tsr_sync_fifo #(
    .WIDTH ($bits(tsr_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_dat   (w_wr_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // seq counts every strobe, stored or dropped, so the host can see gaps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq       <= '0;
      r_lost_pend <= 1'b0;
    end else if (ts_valid) begin
      r_seq       <= r_seq + SEQ_W'(1);
      r_lost_pend <= w_drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_data_nxt   = r_data;
    case (r_state)
      IDLE: if (!w_empty) begin
        w_next_state = BEAT0;
        w_load       = 1'b1;
        w_data_nxt   = pack_beat0(w_head);
      end
      BEAT0: if (m_ready) begin
        w_next_state = BEAT1;
        w_load       = 1'b1;
        w_data_nxt   = pack_beat1(w_head);
      end
      BEAT1: if (m_ready) begin
        // an entry written this cycle is not readable yet, so level>1 is the test
        if (w_level > LVL_W'(1)) begin
          w_next_state = BEAT0;
          w_load       = 1'b1;
          w_data_nxt   = pack_beat0(w_next);
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_data <= '0;
    else if (w_load) r_data <= w_data_nxt;
  end

  always_comb begin
    m_valid = (r_state != IDLE);
    m_last  = (r_state == BEAT1);
    m_data  = r_data;
  end

  assign fifo_level = w_level;

`ifdef TSR_DROP_COUNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign drop_count = r_drop_cnt;
`else
  assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ts_report_packer.sv
// Directed bench for ts_report_packer: queue-based packet model checked every cycle plus literal checkpoints.
module tb_ts_report_packer;

  localparam int DEPTH = 8;
`ifdef TSR_DROP_COUNT_EN
  localparam logic [15:0] D3 = 16'd2;
  localparam logic [15:0] D6 = 16'd6;
`else
  localparam logic [15:0] D3 = 16'd0;
  localparam logic [15:0] D6 = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ts_valid = 1'b0;
  logic [5:0]  ts_utc_seconds = '0;
  logic [25:0] ts_clk_counter = '0;
  logic [12:0] ts_drift = '0;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready = 1'b0;
  logic [3:0]  fifo_level;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  ts_report_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ts_valid       (ts_valid),
    .ts_utc_seconds (ts_utc_seconds),
    .ts_clk_counter (ts_clk_counter),
    .ts_drift       (ts_drift),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .fifo_level     (fifo_level),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_ts(input logic [5:0] u, input logic [25:0] c, input logic [12:0] d);
    ts_utc_seconds = u;
    ts_clk_counter = c;
    ts_drift       = d;
    ts_valid       = 1'b1;
  endtask

  task automatic wait_valid(input logic want, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_valid !== want && n < 64);
    check(name, 32'(m_valid), 32'(want));
  endtask

  // Model: a queue of expected beats and an occupancy count, stepped once per cycle
  typedef struct {
    logic [31:0] dat;
    logic        last;
  } beat_t;

  beat_t       beat_q[$];
  beat_t       exp_b;
  int          m_level;
  logic [7:0]  m_seq;
  logic        m_lost;
  logic [15:0] m_drops;
  logic        prev_stall, prev_last, pop;
  logic [31:0] prev_dat, b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        beat_q.delete();
        m_level = 0; m_seq = '0; m_lost = 1'b0; m_drops = '0; prev_stall = 1'b0;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
      end else begin
        pop = 1'b0;
        check("level", 32'(fifo_level), 32'(m_level));
`ifdef TSR_DROP_COUNT_EN
        check("drop_count", 32'(drop_count), 32'(m_drops));
`else
        check("drop_count", 32'(drop_count), 32'd0);
`endif
        if (prev_stall) begin
          check("hold_valid", 32'(m_valid), 32'd1);
          check("hold_data", m_data, prev_dat);
          check("hold_last", 32'(m_last), 32'(prev_last));
        end
        if (m_valid && m_ready) begin
          check("beat_expected", 32'(beat_q.size() != 0), 32'd1);
          if (beat_q.size() != 0) begin
            exp_b = beat_q.pop_front();
            check("beat_data", m_data, exp_b.dat);
            check("beat_last", 32'(m_last), 32'(exp_b.last));
            pop = exp_b.last;
          end
        end
        if (ts_valid) begin
          if (m_level < DEPTH || pop) begin
            b0 = 32'hA000_0000 | (32'(m_seq) << 20) | (32'(m_lost) << 19)
               | (32'(ts_utc_seconds) << 13) | 32'(ts_drift);
            beat_q.push_back('{dat: b0, last: 1'b0});
            beat_q.push_back('{dat: 32'(ts_clk_counter), last: 1'b1});
            m_level++;
            m_lost = 1'b0;
          end else begin
            m_lost = 1'b1;
            if (m_drops != 16'hFFFF) m_drops++;
          end
          m_seq++;
        end
        if (pop) m_level--;
        prev_stall = m_valid && !m_ready;
        prev_dat   = m_data;
        prev_last  = m_last;
      end
    end
  end

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_m_valid", 32'(m_valid), 32'd0);
    check("reset_m_data", m_data, 32'd0);
    check("reset_m_last", 32'(m_last), 32'd0);
    check("reset_level", 32'(fifo_level), 32'd0);
    check("reset_drops", 32'(drop_count), 32'd0);

    // Single tuple, exact latency
    m_ready = 1'b1;
    @(posedge clk); #1 drive_ts(6'd17, 26'h123456, 13'h1FFD);
    @(negedge clk); check("t1_n_valid", 32'(m_valid), 32'd0);
    @(posedge clk); #1 ts_valid = 1'b0;
    @(negedge clk); check("t1_n1_level", 32'(fifo_level), 32'd1);
    check("t1_n1_valid", 32'(m_valid), 32'd0);
    @(negedge clk); check("t1_n2_valid", 32'(m_valid), 32'd1);
    check("t1_beat0", m_data, 32'hA0023FFD);
    check("t1_beat0_last", 32'(m_last), 32'd0);
    @(negedge clk); check("t1_beat1", m_data, 32'h00123456);
    check("t1_beat1_last", 32'(m_last), 32'd1);
    @(negedge clk); check("t1_done_valid", 32'(m_valid), 32'd0);
    check("t1_done_level", 32'(fifo_level), 32'd0);

    // Backpressure: beat 0 held for 10 cycles
    @(posedge clk); #1 m_ready = 1'b0; drive_ts(6'd5, 26'h3FFFFFF, 13'h0FFF);
    @(posedge clk); #1 ts_valid = 1'b0;
    @(negedge clk); check("bp_n1_valid", 32'(m_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(m_valid), 32'd1);
      check("bp_hold_beat0", m_data, 32'hA010AFFF);
    end
    @(posedge clk); #1 m_ready = 1'b1;
    @(negedge clk); check("bp_rel_last", 32'(m_last), 32'd0);
    check("bp_rel_level", 32'(fifo_level), 32'd1);
    @(negedge clk); check("bp_beat1", m_data, 32'h03FFFFFF);
    check("bp_beat1_last", 32'(m_last), 32'd1);
    @(negedge clk); check("bp_done_level", 32'(fifo_level), 32'd0);
    check("bp_done_valid", 32'(m_valid), 32'd0);

    // Overflow from a fresh reset: 10 strobes into 8 entries
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 drive_ts(6'(i), 26'(i), 13'(i));
    end
    @(posedge clk); #1 ts_valid = 1'b0;
    @(negedge clk); check("ovf_level", 32'(fifo_level), 32'd8);
    check("ovf_drops", 32'(drop_count), 32'(D3));
    check("ovf_head_beat0", m_data, 32'hA0000000);
    @(posedge clk); #1 m_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (m_valid) cnt++;
    end
    check("ovf_back_to_back_beats", 32'(cnt), 32'd16);
    @(negedge clk); check("ovf_drained_valid", 32'(m_valid), 32'd0);
    check("ovf_drained_level", 32'(fifo_level), 32'd0);
    @(posedge clk); #1 drive_ts(6'd3, 26'h0ABCDE, 13'h0010);
    @(posedge clk); #1 ts_valid = 1'b0;
    wait_valid(1'b1, "ovf_next_wait");
    check("ovf_next_beat0_seq10_lost", m_data, 32'hA0A86010);
    @(negedge clk); check("ovf_next_beat1", m_data, 32'h000ABCDE);
    @(negedge clk); check("ovf_next_done", 32'(m_valid), 32'd0);

    // Full plus pop: strobe coincident with a beat-1 handshake
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 m_ready = 1'b0; drive_ts(6'(20 + i), 26'(1000 + i), 13'(i));
    end
    @(posedge clk); #1 ts_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); check("fp_full_level", 32'(fifo_level), 32'd8);
    check("fp_full_valid", 32'(m_valid), 32'd1);
    @(posedge clk); #1 m_ready = 1'b1;
    @(posedge clk); #1 drive_ts(6'd9, 26'h2222222, 13'h1000);
    @(negedge clk); check("fp_beat1_last", 32'(m_last), 32'd1);
    check("fp_beat1_level", 32'(fifo_level), 32'd8);
    @(posedge clk); #1 ts_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk); check("fp_after_level", 32'(fifo_level), 32'd8);
    check("fp_after_drops", 32'(drop_count), 32'(D3));
    check("fp_after_beat0", 32'({m_valid, m_last}), 32'd2);
    @(posedge clk); #1 m_ready = 1'b1;
    wait_valid(1'b0, "fp_drain");

    // Sequence wrap at one tuple per 4 cycles
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1 drive_ts(6'(i % 64), 26'(i * 12345), 13'(i) - 13'd150);
      @(posedge clk); #1 ts_valid = 1'b0;
      repeat (2) @(posedge clk);
    end
    wait_valid(1'b0, "wrap_drain");
    check("wrap_level", 32'(fifo_level), 32'd0);

    // Forced overflow: lost flag on the next stored tuple
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1 m_ready = 1'b0; drive_ts(6'(40 + i), 26'(i), 13'h1F00);
    end
    @(posedge clk); #1 ts_valid = 1'b0;
    @(negedge clk); check("ovf2_level", 32'(fifo_level), 32'd8);
    check("ovf2_drops", 32'(drop_count), 32'(D6));
    @(posedge clk); #1 m_ready = 1'b1;
    wait_valid(1'b0, "ovf2_drain");
    @(posedge clk); #1 drive_ts(6'd1, 26'd7, 13'd7);
    @(posedge clk); #1 ts_valid = 1'b0;
    wait_valid(1'b1, "ovf2_next_wait");
    check("ovf2_lost_bit", 32'(m_data[19]), 32'd1);
    wait_valid(1'b0, "ovf2_next_drain");

    // Async reset during beat 1
    @(posedge clk); #1 m_ready = 1'b0; drive_ts(6'd2, 26'h55, 13'd0);
    @(posedge clk); #1 ts_valid = 1'b0;
    wait_valid(1'b1, "rst_mid_wait");
    @(posedge clk); #1 m_ready = 1'b1;
    @(posedge clk); #1 m_ready = 1'b0;
    @(negedge clk); check("rst_mid_in_beat1", 32'(m_last), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_valid", 32'(m_valid), 32'd0);
    check("rst_mid_last", 32'(m_last), 32'd0);
    check("rst_mid_data", m_data, 32'd0);
    check("rst_mid_level", 32'(fifo_level), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 drive_ts(6'd1, 26'd1, 13'd1);
    @(posedge clk); #1 ts_valid = 1'b0;
    wait_valid(1'b1, "rst_new_wait");
    check("rst_new_beat0_seq0", m_data, 32'hA0002001);
    @(posedge clk); #1 m_ready = 1'b1;
    wait_valid(1'b0, "rst_new_drain");
    check("rst_new_level", 32'(fifo_level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ts_report_packer.md
# ts_report_packer

Downstream stage of the PPS timestamp capture block. It takes each confirmed timestamp tuple (UTC second, clock count since PPS, drift), each marked by a one-cycle `ts_valid` strobe, and queues it in a small FIFO. It then streams each tuple to the host/DMA path as a two-beat, 32-bit valid/ready packet with a sequence number and a loss flag. Timestamps that arrive while the FIFO is full are dropped and accounted for, never silently overwritten.

## Interface
Parameters:
- `UTC_SECONDS_WIDTH`, 6: width of UTC seconds field
- `COUNT_LAST_SECOND_WIDTH`, 26: width of clock-count field
- `DRIFT_COUNT_WIDTH`, 13: width of signed drift field
- `FIFO_DEPTH`, 8: entries; power of two, 2..64

Ports:
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `ts_valid`  in  1  one-cycle strobe; the tuple is valid in this cycle
- `ts_utc_seconds`  in  UTC_SECONDS_WIDTH  captured UTC second
- `ts_clk_counter`  in  COUNT_LAST_SECOND_WIDTH  cycles since last PPS
- `ts_drift`  in  DRIFT_COUNT_WIDTH  signed drift, two's complement
- `m_valid`  out  1  output beat valid
- `m_data`  out  32  output beat
- `m_last`  out  1  high on beat 1 (second beat) of a packet
- `m_ready`  in  1  consumer accepts the beat when `m_valid & m_ready`
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  occupied entries
- `drop_count`  out  16  saturating count of dropped tuples

## Operation
- **Write:** when `ts_valid` is high and the FIFO is not full, or is full but the beat-1 handshake pops the head in the same cycle, store {utc, clk_counter, drift, seq, lost}.
- **Drop:** when `ts_valid` is high, the FIFO is full, and no pop occurs in that cycle, discard the tuple. Set `lost_pend` and increment `drop_count`, which saturates at 16'hFFFF.
- **Sequence:** `seq` is 8 bits and increments on every `ts_valid`, whether the tuple is stored or dropped. The consumer detects gaps from it. `seq` wraps from 255 to 0.
- **Loss flag:** the `lost` field stored with an entry equals `lost_pend`. `lost_pend` clears on that write.
- **Packet format:**
  - Beat 0 = {4'hA tag, seq[7:0], lost, utc[5:0], drift[12:0]}, MSB first (4+8+1+6+13 = 32).
  - Beat 1 = {6'b0, clk_counter[25:0]}.
- **Output FSM:**
  - IDLE: if the FIFO is not empty, load beat 0 from the FIFO head into the output register and go to BEAT0.
  - BEAT0: `m_valid`=1, `m_last`=0. On handshake, load beat 1 and go to BEAT1.
  - BEAT1: `m_valid`=1, `m_last`=1. On handshake, pop the head. If another entry remains after the pop, load its beat 0 and go to BEAT0; otherwise go to IDLE.
- **Stability:** `m_data`/`m_last` hold stable while `m_valid` is high and `m_ready` is low. `m_valid` never drops without a handshake.
- **Reset:** the FIFO empties and pointers clear. State = IDLE; `seq`=0; `lost_pend`=0.

## Timing
- **Reset values:** `m_valid`=0, `m_data`=0, `m_last`=0, `fifo_level`=0, `drop_count`=0.
- **Latency:**
  - `ts_valid` in cycle N → entry written at the edge ending N → `fifo_level` increments in N+1.
  - Beat 0 is loaded at the edge ending N+1 → `m_valid` is high in N+2.
- **Throughput:** with `m_ready` held high, back-to-back packets run at 2 cycles per packet with no idle cycle between them. Sustained input faster than one tuple per 2 cycles fills the FIFO.
- **Full plus pop:** a `ts_valid` in the same cycle as a beat-1 pop while full is stored; `fifo_level` stays at FIFO_DEPTH.
- **Empty plus write:** the head is not readable in the write cycle, so there is no same-cycle bypass.
- **Async reset mid-packet:** outputs clear immediately. The partial packet is abandoned and never resumed.

## Configuration
- Macro: `TSR_DROP_COUNT_EN`.
- Defined: the `drop_count` counter is implemented as described.
- Undefined: the counter logic is removed and `drop_count` is tied to 16'h0000. The `lost` flag and `seq` behaviour are unchanged.

## Structure
- Package `tsr_pkg`:
  - field widths
  - `TSR_TAG` = 4'hA
  - packed entry typedef {utc, clk_counter, drift, seq, lost}, 6+26+13+8+1 = 54 bits
  - FSM state enum {IDLE, BEAT0, BEAT1}
- Sub-module `tsr_sync_fifo`:
  - synchronous FIFO, width/depth parameters, head always readable
  - ports: push, pop, full, empty, level
  - drop logic and FSM live in the top module.

## Test plan
- **Single tuple:** utc=17, clk_counter=26'h123456, drift=-3, `m_ready`=1 → `m_valid` high from N+2. Beat 0 = 0xA0_0_11_1FFD packed as {A,00,0,010001,1_1111_1111_1101}, i.e. 32'hA0023FFD. Beat 1 = 32'h00123456 with `m_last`=1.
- **Backpressure:** `m_ready`=0 for 10 cycles, then 1 → beat 0 held stable throughout; then two handshakes; `fifo_level` returns 1→0.
- **Overflow:** `m_ready`=0, 10 strobes with FIFO_DEPTH=8 → `fifo_level`=8, `drop_count`=2. Release `m_ready`: 8 packets with seq 0..7, all `lost`=0. Next strobe: seq=10, `lost`=1.
- **Full plus pop:** full FIFO, strobe coincident with a beat-1 handshake → tuple stored, `fifo_level` stays 8, `drop_count` unchanged.
- **Seq wrap and saturation:** 300 strobes with `m_ready`=1 at 1 per 4 cycles → seq goes 255→0 with no `lost` flags. With `TSR_DROP_COUNT_EN` undefined, forced overflow → `drop_count` stays 0 while `lost`=1 still appears.
- **Reset mid-packet:** `rst_n` low during BEAT1 → `m_valid`=0 immediately. After release: `fifo_level`=0, first new packet has seq=0.
